morsecode_receiver: RTL



---
 rtl/morsecode_pkg.sv | 40 ++++
 rtl/morsecode_decoder_lut.sv | 29 ++
 rtl/morsecode_receiver.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/morsecode_pkg.sv
// Shared definitions for the Morse receive path: FSM state encoding, letter
// codes A..H, decode-table keys and default timing parameters.
// Keys are {sym_cnt[2:0], sym_reg[3:0]}. Symbols shift in at the LSB, with
// dash = 1 and dot = 0. Unused upper bits of sym_reg are zero.
package morsecode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  localparam int DASH_MIN_DEF = 2;
  localparam int DASH_MAX_DEF = 3;
  localparam int GAP_LTR_DEF  = 3;
  localparam int SYM_MAX_DEF  = 4;
  localparam int CNT_W_DEF    = 4;

  localparam int SYM_W = 4;

  localparam logic [2:0] LTR_A = 3'd0;
  localparam logic [2:0] LTR_B = 3'd1;
  localparam logic [2:0] LTR_C = 3'd2;
  localparam logic [2:0] LTR_D = 3'd3;
  localparam logic [2:0] LTR_E = 3'd4;
  localparam logic [2:0] LTR_F = 3'd5;
  localparam logic [2:0] LTR_G = 3'd6;
  localparam logic [2:0] LTR_H = 3'd7;

  localparam logic [6:0] KEY_A = {3'd2, 4'b0001};
  localparam logic [6:0] KEY_B = {3'd4, 4'b1000};
  localparam logic [6:0] KEY_C = {3'd4, 4'b1010};
  localparam logic [6:0] KEY_D = {3'd3, 4'b0100};
  localparam logic [6:0] KEY_E = {3'd1, 4'b0000};
  localparam logic [6:0] KEY_F = {3'd4, 4'b0010};
  localparam logic [6:0] KEY_G = {3'd3, 4'b0110};
  localparam logic [6:0] KEY_H = {3'd4, 4'b0000};

endpackage

// File: rtl/morsecode_decoder_lut.sv
// Combinational symbol-pattern to letter lookup. This is the inverse of the
// transmitter's encode table. A pattern with no matching letter clears hit_o.
module morsecode_decoder_lut
  import morsecode_pkg::*;
(
  input  logic [2:0]       sym_cnt_i,
  input  logic [SYM_W-1:0] sym_reg_i,
  output logic             hit_o,
  output logic [2:0]       letter_o
);

  // Match the {count, pattern} key against the eight known letters
  always_comb begin
    hit_o    = 1'b1;
    letter_o = LTR_A;
    case ({sym_cnt_i, sym_reg_i})
      KEY_A:   letter_o = LTR_A;
      KEY_B:   letter_o = LTR_B;
      KEY_C:   letter_o = LTR_C;
      KEY_D:   letter_o = LTR_D;
      KEY_E:   letter_o = LTR_E;
      KEY_F:   letter_o = LTR_F;
      KEY_G:   letter_o = LTR_G;
      KEY_H:   letter_o = LTR_H;
      default: hit_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/morsecode_receiver.sv
// Morse receiver. It samples the line on each tick_en and measures mark and
// space run lengths. Each mark is classified as a dot or a dash, and letters
// A..H are decoded.
// Optional feature: define MORSE_RX_SYNC_EN to pass morse_in through a
// 2-flop synchroniser before sampling.
// letter_valid and letter_err are combinational strobes qualified by tick_en.
// They assert during the tick whose edge ends the letter. letter_out shows
// the new code in that same cycle.
module morsecode_receiver
  import morsecode_pkg::*;
#(
  parameter int DASH_MIN = DASH_MIN_DEF,
  parameter int DASH_MAX = DASH_MAX_DEF,
  parameter int GAP_LTR  = GAP_LTR_DEF,
  parameter int SYM_MAX  = SYM_MAX_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_en,
  input  logic       morse_in,
  output logic [2:0] letter_out,
  output logic       letter_valid,
  output logic       letter_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] DASH_MIN_C = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] DASH_MAX_C = CNT_W'(DASH_MAX);
  localparam logic [CNT_W-1:0] GAP_LTR_C  = CNT_W'(GAP_LTR);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [2:0]       SYM_MAX_C  = 3'(SYM_MAX);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [SYM_W-1:0] sym_reg_q, sym_reg_d;
  logic [2:0]       sym_cnt_q, sym_cnt_d;
  logic [2:0]       letter_q, letter_d;

  logic             lineS;
  logic [CNT_W-1:0] runInc;
  logic             lutHit;
  logic [2:0]       lutLetter;
  logic             validPulse;
  logic             errPulse;

`ifdef MORSE_RX_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchroniser for an asynchronous key input, clocked every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], morse_in};
  end

  assign lineS = sync_q[1];
`else
  assign lineS = morse_in;
`endif

  assign runInc = (run_q == '1) ? run_q : run_q + ONE_C;

  morsecode_decoder_lut u_lut (
    .sym_cnt_i (sym_cnt_q),
    .sym_reg_i (sym_reg_q),
    .hit_o     (lutHit),
    .letter_o  (lutLetter)
  );

  // Next-state logic; nothing moves unless this cycle carries a tick
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    sym_reg_d  = sym_reg_q;
    sym_cnt_d  = sym_cnt_q;
    letter_d   = letter_q;
    validPulse = 1'b0;
    errPulse   = 1'b0;
    if (tick_en) begin
      case (state_q)
        ST_IDLE: begin
          if (lineS) begin
            state_d   = ST_MARK;
            run_d     = ONE_C;
            sym_reg_d = '0;
            sym_cnt_d = 3'd0;
          end
        end
        ST_MARK: begin
          if (lineS) begin
            if (runInc > DASH_MAX_C) begin
              state_d = ST_ERR;
              run_d   = '0;
            end else begin
              run_d = runInc;
            end
          end else begin
            sym_reg_d = {sym_reg_q[SYM_W-2:0], (run_q >= DASH_MIN_C)};
            run_d     = ONE_C;
            if (sym_cnt_q == SYM_MAX_C) begin
              state_d = ST_ERR;
            end else begin
              sym_cnt_d = sym_cnt_q + 3'd1;
              state_d   = ST_SPACE;
            end
          end
        end
        ST_SPACE: begin
          if (lineS) begin
            state_d = ST_MARK;
            run_d   = ONE_C;
          end else if (runInc == GAP_LTR_C) begin
            state_d = ST_IDLE;
            run_d   = '0;
            if (lutHit) begin
              validPulse = 1'b1;
              letter_d   = lutLetter;
            end else begin
              errPulse = 1'b1;
            end
          end else begin
            run_d = runInc;
          end
        end
        ST_ERR: begin
          if (lineS) begin
            run_d = '0;
          end else if (runInc == GAP_LTR_C) begin
            state_d  = ST_IDLE;
            run_d    = '0;
            errPulse = 1'b1;
          end else begin
            run_d = runInc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  // State, counters and held letter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      run_q     <= '0;
      sym_reg_q <= '0;
      sym_cnt_q <= 3'd0;
      letter_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      sym_reg_q <= sym_reg_d;
      sym_cnt_q <= sym_cnt_d;
      letter_q  <= letter_d;
    end
  end

  assign letter_out   = letter_d;
  assign letter_valid = validPulse;
  assign letter_err   = errPulse;
  assign busy         = (state_q != ST_IDLE);

endmodule
